// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store unit at the memory end of the CPU datapath. Takes one memory
//   op from the datapath, runs a level-held rd/wr + ack handshake with the
//   data RAM and returns load data on regfile write port 1. Holds the
//   pipeline through `stall` while a RAM access is outstanding.
//
// Ports
//   clk, rst_n           clock, async active-low reset
//   req_*                request from datapath (valid/ready, load, byte,
//                        addr, wdata, rd)
//   stall                pipeline hold
//   mem_*                RAM handshake (addr, wdata, be, rd, wr, rdata, ack)
//   ram_data2, w_addr1,
//   w_en1, forward_w_data  load writeback to the register file
//   align_fault          1-cycle pulse: misaligned word request rejected
//   bus_fault            1-cycle pulse: RAM did not ack within TIMEOUT
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | ready for a new request
// S_REQ  | rd/wr held towards RAM, waiting for mem_ack or timeout
// S_WB   | one-cycle regfile writeback of captured load data

module mem_access_unit #(
  parameter int RAM_ADDR_W = 11,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_load,
  input  logic                  req_byte,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_rd,
  output logic                  stall,
  output logic [RAM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  output logic                  mem_rd,
  output logic                  mem_wr,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack,
  output logic [31:0]           ram_data2,
  output logic [3:0]            w_addr1,
  output logic                  w_en1,
  output logic                  forward_w_data,
  output logic                  align_fault,
  output logic                  bus_fault
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic                    load_q, load_d;
  logic [1:0]              lane_q, lane_d;
  logic                    byte_q, byte_d;
  logic [3:0]              rd_q, rd_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [RAM_ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]             mem_wdata_q, mem_wdata_d;
  logic [3:0]              mem_be_q, mem_be_d;
  logic [31:0]             ram_data2_q, ram_data2_d;
  logic [3:0]              w_addr1_q, w_addr1_d;
  logic                    align_fault_q, align_fault_d;
  logic                    bus_fault_q, bus_fault_d;

  logic                    is_idle;
  logic                    accept;
  logic                    misalign;
  logic [31:0]             load_data;

  assign is_idle  = (state_q == S_IDLE);
  assign accept   = is_idle & req_valid & (req_byte | (req_addr[1:0] == 2'b00));
  assign misalign = is_idle & req_valid & ~req_byte & (req_addr[1:0] != 2'b00);

  // Byte loads pick the addressed lane and zero-extend.
  always_comb begin
    load_data = mem_rdata;
    if (byte_q) begin
      case (lane_q)
        2'd0:    load_data = {24'b0, mem_rdata[7:0]};
        2'd1:    load_data = {24'b0, mem_rdata[15:8]};
        2'd2:    load_data = {24'b0, mem_rdata[23:16]};
        default: load_data = {24'b0, mem_rdata[31:24]};
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    load_d        = load_q;
    lane_d        = lane_q;
    byte_d        = byte_q;
    rd_d          = rd_q;
    cnt_d         = cnt_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;
    ram_data2_d   = ram_data2_q;
    w_addr1_d     = w_addr1_q;
    align_fault_d = misalign;
    bus_fault_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          load_d     = req_load;
          byte_d     = req_byte;
          lane_d     = req_addr[1:0];
          rd_d       = req_rd;
          cnt_d      = 8'd0;
          mem_addr_d = req_addr[RAM_ADDR_W+1:2];
          if (req_byte) begin
            mem_be_d    = 4'b0001 << req_addr[1:0];
            mem_wdata_d = {4{req_wdata[7:0]}};
          end else begin
            mem_be_d    = 4'hF;
            mem_wdata_d = req_wdata;
          end
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          if (load_q) begin
            ram_data2_d = load_data;
            w_addr1_d   = rd_q;
            state_d     = S_WB;
          end else begin
            state_d = S_IDLE;
          end
        end else if (cnt_q == CNT_LAST) begin
          bus_fault_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      load_q        <= 1'b0;
      lane_q        <= 2'd0;
      byte_q        <= 1'b0;
      rd_q          <= 4'd0;
      cnt_q         <= 8'd0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= 32'd0;
      mem_be_q      <= 4'd0;
      ram_data2_q   <= 32'd0;
      w_addr1_q     <= 4'd0;
      align_fault_q <= 1'b0;
      bus_fault_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_q        <= load_d;
      lane_q        <= lane_d;
      byte_q        <= byte_d;
      rd_q          <= rd_d;
      cnt_q         <= cnt_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
      ram_data2_q   <= ram_data2_d;
      w_addr1_q     <= w_addr1_d;
      align_fault_q <= align_fault_d;
      bus_fault_q   <= bus_fault_d;
    end
  end

  // Handshake strobes decode straight from state so an async reset drops
  // them without waiting for a clock edge.
  assign req_ready      = is_idle;
  assign stall          = (state_q == S_REQ) | accept;
  assign mem_rd         = (state_q == S_REQ) & load_q;
  assign mem_wr         = (state_q == S_REQ) & ~load_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_be         = mem_be_q;
  assign ram_data2      = ram_data2_q;
  assign w_addr1        = w_addr1_q;
  assign w_en1          = (state_q == S_WB);
  assign forward_w_data = (state_q == S_WB);
  assign align_fault    = align_fault_q;
  assign bus_fault      = bus_fault_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit at the memory end of the CPU datapath. It accepts a memory request formed from the datapath's address result and store data. It runs a level-held request/acknowledge handshake with the data RAM and returns load data on the datapath's memory write port (`ram_data2`, `w_addr1`, `w_en1`, `forward_w_data`). While a request is outstanding it asserts `stall` to freeze the pipeline.

## Interface
- `RAM_ADDR_W`, 11, RAM word-address width; RAM index is `req_addr[RAM_ADDR_W+1:2]`
- `TIMEOUT`, 255, maximum REQ-state cycles without `mem_ack` before the request is aborted (1..255)

Ports:
- `clk`  in  1  clock; one clock domain, all logic on rising edge
- `rst_n`  in  1  asynchronous reset, active-low
- `req_valid`  in  1  datapath presents a memory op this cycle
- `req_ready`  out  1  unit can accept; equals (state == IDLE)
- `req_load`  in  1  1 = LDR/LDRB, 0 = STR/STRB
- `req_byte`  in  1  1 = byte access, 0 = word access
- `req_addr`  in  32  byte address (datapath ALU/post-index result)
- `req_wdata`  in  32  store data (register-file store read port)
- `req_rd`  in  4  load destination register
- `stall`  out  1  pipeline hold
- `mem_addr`  out  RAM_ADDR_W  RAM word address
- `mem_wdata`  out  32  RAM write data
- `mem_be`  out  4  byte enables; bit i selects bits [8i+7:8i]
- `mem_rd`  out  1  read request, held until ack
- `mem_wr`  out  1  write request, held until ack
- `mem_rdata`  in  32  RAM read data, valid when `mem_ack` = 1
- `mem_ack`  in  1  RAM completion
- `ram_data2`  out  32  load result to the datapath
- `w_addr1`  out  4  register-file write address
- `w_en1`  out  1  register-file write enable
- `forward_w_data`  out  1  selects `ram_data2` onto regfile write port 1
- `align_fault`  out  1  one-cycle pulse: misaligned word request rejected
- `bus_fault`  out  1  one-cycle pulse: request timed out

## Operation
- FSM states: IDLE, REQ, WB.
- IDLE:
  - On `req_valid` with `req_byte` = 1, or with `req_addr[1:0]` = 0: latch load, byte, addr, wdata and rd, clear the timeout counter, go to REQ.
  - On `req_valid` with `req_byte` = 0 and `req_addr[1:0]` != 0: pulse `align_fault` next cycle, stay in IDLE, issue no RAM access and no writeback.
- REQ:
  - Drive `mem_rd` = load or `mem_wr` = !load. Hold `mem_addr`, `mem_wdata` and `mem_be` stable.
  - On `mem_ack`: a load captures the extracted data and goes to WB; a store goes to IDLE.
  - If `mem_ack` is still 0 when the counter reaches TIMEOUT-1: pulse `bus_fault`, go to IDLE, no writeback.
- WB: `w_en1` = 1, `forward_w_data` = 1, `w_addr1` = latched rd, `ram_data2` = captured data. Exactly one cycle, then IDLE.
- Word access: `mem_be` = 4'hF, `mem_wdata` = wdata, load data = `mem_rdata`.
- Byte access with lane = addr[1:0]:
  - `mem_be` = 4'b0001 << lane, `mem_wdata` = {4{wdata[7:0]}}.
  - Load data = {24'b0, `mem_rdata`[8·lane+7 : 8·lane]}, zero-extended.
- `stall` = (state == REQ) | (state == IDLE & `req_valid` & request accepted). `stall` is low in WB and on a rejected request.
- `req_valid` is ignored outside IDLE; the datapath holds its request because `stall` is high.
- Outputs in non-WB states: `w_en1` = 0, `forward_w_data` = 0. `ram_data2` and `w_addr1` hold their last values.

## Timing
- Reset (async, `rst_n` low):
  - State = IDLE, counter = 0.
  - All outputs 0 except `req_ready` = 1 and `mem_be` = 0.
  - Asserting reset mid-request drops `mem_rd`/`mem_wr` immediately. No writeback occurs.
- Store: accept at T0, REQ from T1, ack at Tk, IDLE at Tk+1. Minimum 2 cycles.
- Load: accept at T0, ack at Tk, WB at Tk+1, IDLE at Tk+2. Minimum 3 cycles.
- `mem_ack` is sampled only in REQ; an ack in any other state is ignored.
- `mem_rdata` is captured on the ack edge. It need not stay valid afterwards.
- Timeout: with no ack, REQ lasts exactly TIMEOUT cycles. `bus_fault` is high on the first IDLE cycle.
- A new request may be accepted in the first IDLE cycle after WB or after store completion. There are no bubbles beyond those listed.

## Test plan
- Word store, addr 0x0000_0010, data 0xDEADBEEF, ack in the 1st REQ cycle -> `mem_addr` = 4, `mem_be` = F, `mem_wr` high 1 cycle, `stall` high 2 cycles, no `w_en1`.
- Byte load, addr 0x0000_0013, `mem_rdata` = 0xA1B2C3D4, rd = 5, ack after 3 REQ cycles -> `mem_be` = 8, WB cycle with `ram_data2` = 0x0000_00A1, `w_addr1` = 5, `w_en1` = `forward_w_data` = 1.
- Byte store, addr 0x0000_0022, wdata 0x1234_5678 -> `mem_wdata` = 0x7878_7878, `mem_be` = 4'b0100.
- Word load at addr 0x0000_0006 -> `align_fault` pulse, `mem_rd` never asserted, `req_ready` stays 1.
- TIMEOUT = 4, load with ack never asserted -> `mem_rd` high exactly 4 cycles, `bus_fault` pulses, no WB; a back-to-back store is then accepted normally.
- `rst_n` low during REQ of a load -> `mem_rd`, `stall`, `w_en1` = 0 immediately; after release the unit is in IDLE and a later ack is ignored.
